// File: rtl/rr_arbiter.sv
// N-way round-robin arbiter with a registered one-hot grant and rotating priority pointer.
// Optional feature: define RR_ARB_LOCK_EN to let an owner keep its grant for up to MAX_HOLD cycles.
module rr_arbiter #(
  parameter int N        = 4,
  parameter int MAX_HOLD = 8,
  localparam int IDW     = $clog2(N)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           en,
  input  logic [N-1:0]   req,
  output logic [N-1:0]   gnt,
  output logic [IDW-1:0] gnt_id,
  output logic           gnt_valid
);

  if (N < 2 || N > 32) begin : g_bad_n
    $error("rr_arbiter: N must be in 2..32");
  end
  if (MAX_HOLD < 1 || MAX_HOLD > 255) begin : g_bad_hold
    $error("rr_arbiter: MAX_HOLD must be in 1..255");
  end

  logic [N-1:0]   gnt_q, gnt_d;
  logic [IDW-1:0] gnt_id_q, gnt_id_d;
  logic [IDW-1:0] ptr_q, ptr_d;
`ifdef RR_ARB_LOCK_EN
  logic [7:0]     hold_cnt_q, hold_cnt_d;
`endif
  int             win;

  // Rotating the doubled request vector by ptr puts the highest-priority
  // requester at bit 0; the lowest set bit then maps back to the winner index.
  function automatic int rr_pick(input logic [N-1:0] r, input logic [IDW-1:0] p);
    logic [2*N-1:0] dbl;
    int             w;
    dbl = {r, r} >> p;
    w   = -1;
    for (int i = N - 1; i >= 0; i--) begin
      if ((dbl & ((2*N)'(1) << i)) != '0) begin
        w = int'(p) + i;
        if (w >= N) w = w - N;
      end
    end
    return w;
  endfunction

  always_comb begin
    gnt_d    = gnt_q;
    gnt_id_d = gnt_id_q;
    ptr_d    = ptr_q;
`ifdef RR_ARB_LOCK_EN
    hold_cnt_d = hold_cnt_q;
`endif
    win = rr_pick(req, ptr_q);
    if (!en || win < 0) begin
      gnt_d    = '0;
      gnt_id_d = '0;
`ifdef RR_ARB_LOCK_EN
      hold_cnt_d = '0;
`endif
    end
`ifdef RR_ARB_LOCK_EN
    else if (gnt_q != '0 && (req & gnt_q) != '0 && hold_cnt_q < 8'(MAX_HOLD)) begin
      hold_cnt_d = hold_cnt_q + 8'd1;
    end
`endif
    else begin
      gnt_d    = N'(1) << win;
      gnt_id_d = IDW'(win);
      ptr_d    = (win == N - 1) ? '0 : IDW'(win + 1);
`ifdef RR_ARB_LOCK_EN
      hold_cnt_d = 8'd1;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      gnt_q    <= '0;
      gnt_id_q <= '0;
      ptr_q    <= '0;
`ifdef RR_ARB_LOCK_EN
      hold_cnt_q <= '0;
`endif
    end else begin
      gnt_q    <= gnt_d;
      gnt_id_q <= gnt_id_d;
      ptr_q    <= ptr_d;
`ifdef RR_ARB_LOCK_EN
      hold_cnt_q <= hold_cnt_d;
`endif
    end
  end

  assign gnt       = gnt_q;
  assign gnt_id    = gnt_id_q;
  assign gnt_valid = |gnt_q;

endmodule

// File: tb/tb_rr_arbiter.sv
// Bench for rr_arbiter (N=4, MAX_HOLD=3): directed scenarios plus randomized traffic
// checked against a behavioural owner/pointer model of the arbitration rules.
module tb_rr_arbiter;
  localparam int N        = 4;
  localparam int MAX_HOLD = 3;
`ifdef RR_ARB_LOCK_EN
  localparam bit LOCK = 1'b1;
`else
  localparam bit LOCK = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         en  = 1'b0;
  logic [N-1:0] req = '0;
  logic [N-1:0] gnt;
  logic [1:0]   gnt_id;
  logic         gnt_valid;

  int errors = 0;
  int checks = 0;

  // Reference state: priority pointer, current owner (-1 = none), cycles held.
  int m_ptr   = 0;
  int m_owner = -1;
  int m_hold  = 0;

  rr_arbiter #(.N(N), .MAX_HOLD(MAX_HOLD)) dut (
    .clk(clk), .rst(rst), .en(en), .req(req),
    .gnt(gnt), .gnt_id(gnt_id), .gnt_valid(gnt_valid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit has_req(input logic [N-1:0] r, input int i);
    return ((r >> i) & 4'b0001) != 4'b0000;
  endfunction

  task automatic model_update(input logic r_i, input logic en_i, input logic [N-1:0] req_i);
    int c;
    if (r_i) begin
      m_ptr = 0; m_owner = -1; m_hold = 0;
    end else if (!en_i || req_i == '0) begin
      m_owner = -1; m_hold = 0;
    end else if (LOCK && m_owner >= 0 && has_req(req_i, m_owner) && m_hold < MAX_HOLD) begin
      m_hold++;
    end else begin
      for (int k = 0; k < N; k++) begin
        c = (m_ptr + k) % N;
        if (has_req(req_i, c)) begin
          m_owner = c;
          m_ptr   = (c + 1) % N;
          m_hold  = 1;
          break;
        end
      end
    end
  endtask

  // Apply one cycle of inputs, advance the model, then check all outputs.
  task automatic step(input logic r_i, input logic en_i, input logic [N-1:0] req_i);
    logic [N-1:0] exp_gnt;
    rst = r_i; en = en_i; req = req_i;
    @(posedge clk);
    model_update(r_i, en_i, req_i);
    #1;
    exp_gnt = (m_owner >= 0) ? (4'b0001 << m_owner) : 4'b0000;
    chk("gnt", 32'(gnt), 32'(exp_gnt));
    chk("gnt_id", 32'(gnt_id), (m_owner >= 0) ? 32'(m_owner) : 32'd0);
    chk("gnt_valid", 32'(gnt_valid), 32'(m_owner >= 0));
    chk("onehot", 32'($onehot0(gnt)), 32'd1);
    chk("no_unreq_gnt", 32'(gnt & ~(r_i ? 4'b0000 : req_i)), 32'd0);
  endtask

  initial begin
    // Reset held two cycles with all requests up.
    step(1'b1, 1'b1, 4'b1111);
    step(1'b1, 1'b1, 4'b1111);
    chk("rst_gnt", 32'(gnt), 32'd0);
    chk("rst_id", 32'(gnt_id), 32'd0);
    chk("rst_valid", 32'(gnt_valid), 32'd0);
    step(1'b0, 1'b1, 4'b1111);
    chk("first_gnt", 32'(gnt), 32'h1);

    if (!LOCK) begin
      step(1'b0, 1'b1, 4'b1111); chk("rr_1", 32'(gnt), 32'h2);
      step(1'b0, 1'b1, 4'b1111); chk("rr_2", 32'(gnt), 32'h4);
      step(1'b0, 1'b1, 4'b1111); chk("rr_3", 32'(gnt), 32'h8);
      step(1'b0, 1'b1, 4'b1111); chk("rr_wrap", 32'(gnt), 32'h1);
      // Pointer to 2, then two requesters below it.
      step(1'b0, 1'b1, 4'b0010); chk("p2_set", 32'(gnt), 32'h2);
      step(1'b0, 1'b1, 4'b0011); chk("p2_a", 32'(gnt), 32'h1);
      step(1'b0, 1'b1, 4'b0011); chk("p2_b", 32'(gnt), 32'h2);
      step(1'b0, 1'b1, 4'b0011); chk("p2_c", 32'(gnt), 32'h1);
      // Requests while disabled are ignored; pointer (now 1) is kept.
      step(1'b0, 1'b0, 4'b1111); chk("dis_gnt", 32'(gnt), 32'h0);
      step(1'b0, 1'b0, 4'b0001); chk("dis_gnt2", 32'(gnt), 32'h0);
      step(1'b0, 1'b1, 4'b1011); chk("dis_resume", 32'(gnt), 32'h2);
    end else begin
      step(1'b1, 1'b1, 4'b0000);
      step(1'b0, 1'b1, 4'b0101); chk("lk_a1", 32'(gnt), 32'h1);
      step(1'b0, 1'b1, 4'b0101); chk("lk_a2", 32'(gnt), 32'h1);
      step(1'b0, 1'b1, 4'b0101); chk("lk_a3", 32'(gnt), 32'h1);
      step(1'b0, 1'b1, 4'b0101); chk("lk_b1", 32'(gnt), 32'h4);
      step(1'b0, 1'b1, 4'b0101); chk("lk_b2", 32'(gnt), 32'h4);
      step(1'b0, 1'b1, 4'b0101); chk("lk_b3", 32'(gnt), 32'h4);
      step(1'b0, 1'b1, 4'b0101); chk("lk_c1", 32'(gnt), 32'h1);
      // Single requester is re-granted after MAX_HOLD with no bubble.
      step(1'b0, 1'b1, 4'b0001); chk("lk_solo2", 32'(gnt), 32'h1);
      step(1'b0, 1'b1, 4'b0001); chk("lk_solo3", 32'(gnt), 32'h1);
      step(1'b0, 1'b1, 4'b0001); chk("lk_solo4", 32'(gnt), 32'h1);
      step(1'b1, 1'b1, 4'b0000);
      step(1'b0, 1'b1, 4'b0010); chk("sw_own", 32'(gnt), 32'h2);
      step(1'b0, 1'b1, 4'b1000); chk("sw_new", 32'(gnt), 32'h8);
    end

    // Disable mid-hold, then reset while owned.
    step(1'b1, 1'b1, 4'b0000);
    step(1'b0, 1'b1, 4'b0100); chk("hold_own", 32'(gnt), 32'h4);
    step(1'b0, 1'b0, 4'b0100); chk("en_drop", 32'(gnt), 32'h0);
    step(1'b0, 1'b1, 4'b0100); chk("reown", 32'(gnt), 32'h4);
    step(1'b1, 1'b1, 4'b0100); chk("rst_owned", 32'(gnt), 32'h0);
    chk("rst_owned_id", 32'(gnt_id), 32'd0);
    step(1'b0, 1'b1, 4'b1111); chk("rst_ptr0", 32'(gnt), 32'h1);

    // Randomized traffic against the model.
    for (int n = 0; n < 400; n++) begin
      step($urandom_range(0, 59) == 0, $urandom_range(0, 7) != 0,
           ($urandom_range(0, 3) == 0) ? 4'b0101 : 4'($urandom));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
